// File: rtl/seven_seg_scan_mux.sv
// Scans NUM_DIGITS 7-segment patterns onto a shared segment bus, one anode per digit.
// A shadow copy of the inputs is taken once per frame, and each digit slot opens with a dark dead-time.
module seven_seg_scan_mux #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 500,
  parameter int ANODE_ACT_LOW = 1,
  parameter int SEG_ACT_LOW   = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 en,
  input  logic [7*NUM_DIGITS-1:0]                              seg_in,
  input  logic [NUM_DIGITS-1:0]                                dp_in,
  output logic [NUM_DIGITS-1:0]                                an,
  output logic [6:0]                                           seg,
  output logic                                                 dp,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                                 frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = (ANODE_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [6:0]            SEG_OFF    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF     = (SEG_ACT_LOW != 0);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7*NUM_DIGITS-1:0] sh_seg_q, sh_seg_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    tick_q, tick_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic [NUM_DIGITS-1:0]   an_on;
  logic [6:0]              seg_on;
  logic                    dp_on;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_seg_d = sh_seg_q;
    sh_dp_d  = sh_dp_q;
    tick_d   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          cnt_d    = '0;
          idx_d    = '0;
          sh_seg_d = seg_in;
          sh_dp_d  = dp_in;
          tick_d   = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = ON;
        end
        ON: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            // Shadow reloads only at the frame wrap so a frame never mixes old and new data
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              sh_seg_d = seg_in;
              sh_dp_d  = dp_in;
              tick_d   = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pin values are derived from next-state so they land on the same edge as the state
  always_comb begin
    an_on  = '0;
    seg_on = '0;
    dp_on  = 1'b0;
    if (state_d == ON) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          an_on[i] = 1'b1;
          seg_on   = sh_seg_d[7*i +: 7];
          dp_on    = sh_dp_d[i];
        end
      end
    end
    an_d  = (ANODE_ACT_LOW != 0) ? ~an_on : an_on;
    seg_d = (SEG_ACT_LOW != 0) ? ~seg_on : seg_on;
    dp_d  = (SEG_ACT_LOW != 0) ? ~dp_on : dp_on;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_seg_q <= '0;
      sh_dp_q  <= '0;
      tick_q   <= 1'b0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_seg_q <= sh_seg_d;
      sh_dp_q  <= sh_dp_d;
      tick_q   <= tick_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux: 4 digits, 8-cycle slots with 2 dark cycles.
// A second instance with active-high anodes shares the stimulus.
module tb_seven_seg_scan_mux;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [27:0] seg_in;
  logic [3:0]  dp_in;
  logic [3:0]  an, an_hi;
  logic [6:0]  seg, seg_hi;
  logic        dp, dp_hi;
  logic [1:0]  digit_idx, digit_idx_hi;
  logic        frame_tick, frame_tick_hi;

  int checks = 0;
  int errors = 0;

  logic [27:0] segInit;
  logic [27:0] segNew;

  seven_seg_scan_mux #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  seven_seg_scan_mux #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ANODE_ACT_LOW(0), .SEG_ACT_LOW(1)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in), .dp_in(dp_in),
    .an(an_hi), .seg(seg_hi), .dp(dp_hi), .digit_idx(digit_idx_hi), .frame_tick(frame_tick_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] expAn, input logic [3:0] expAnHi,
                             input logic [6:0] expSeg, input logic expDp, input logic [1:0] expIdx,
                             input logic expTick);
    checks++;
    assert (an === expAn) else begin
      errors++; $error("[TB] FAIL %s an: got %b expected %b", tag, an, expAn);
    end
    checks++;
    assert (an_hi === expAnHi) else begin
      errors++; $error("[TB] FAIL %s an_hi: got %b expected %b", tag, an_hi, expAnHi);
    end
    checks++;
    assert (seg === expSeg) else begin
      errors++; $error("[TB] FAIL %s seg: got %h expected %h", tag, seg, expSeg);
    end
    checks++;
    assert (dp === expDp) else begin
      errors++; $error("[TB] FAIL %s dp: got %b expected %b", tag, dp, expDp);
    end
    checks++;
    assert (digit_idx === expIdx) else begin
      errors++; $error("[TB] FAIL %s digit_idx: got %0d expected %0d", tag, digit_idx, expIdx);
    end
    checks++;
    assert (frame_tick === expTick) else begin
      errors++; $error("[TB] FAIL %s frame_tick: got %b expected %b", tag, frame_tick, expTick);
    end
  endtask

  task automatic checkOff(input string tag);
    checkOutput(tag, 4'b1111, 4'b0000, 7'h7F, 1'b1, 2'd0, 1'b0);
  endtask

  // Walks nCyc cycles of a frame from cycle 0, optionally changing seg_in at chgCyc
  task automatic applyStimulus(input string tag, input logic [27:0] shSeg, input logic [3:0] shDp,
                               input int nCyc, input int chgCyc, input logic [27:0] chgVal);
    int slot;
    int pos;
    logic lit;
    logic [6:0] pat;
    logic [3:0] expAn, expAnHi;
    logic [6:0] expSeg;
    logic expDp;
    for (int c = 0; c < nCyc; c++) begin
      slot    = c / 8;
      pos     = c % 8;
      lit     = (pos >= 2);
      pat     = shSeg[7*slot +: 7];
      expAnHi = lit ? (4'b0001 << slot) : 4'b0000;
      expAn   = ~expAnHi;
      expSeg  = lit ? ~pat : 7'h7F;
      expDp   = lit ? ~shDp[slot] : 1'b1;
      checkOutput($sformatf("%s_c%0d", tag, c), expAn, expAnHi, expSeg, expDp, 2'(slot), (c == 0));
      if (c == chgCyc) seg_in = chgVal;
      @(negedge clk);
    end
  endtask

  initial begin
    segInit = {7'b0000001, 7'h7E, 7'h7E, 7'h7E};
    segNew  = {7'b0000001, 7'h7E, 7'h7E, 7'h30};
    rst_n   = 1'b0;
    en      = 1'b0;
    seg_in  = segInit;
    dp_in   = 4'b0100;

    // Reset state, then enable held low after release
    @(negedge clk);
    checkOff("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOff("idle0");
    @(negedge clk);
    checkOff("idle1");

    // First frame: slot pattern, dp on digit 2, frame_tick every 32 cycles
    en = 1'b1;
    @(negedge clk);
    applyStimulus("frame1", segInit, 4'b0100, 32, -1, segInit);

    // Mid-frame input change stays invisible until the next frame
    applyStimulus("frame2", segInit, 4'b0100, 32, 10, segNew);
    applyStimulus("frame3", segNew, 4'b0100, 32, -1, segNew);

    // Enable drop during digit 1 lit time
    applyStimulus("frame4", segNew, 4'b0100, 10, -1, segNew);
    checkOutput("d1_lit", 4'b1101, 4'b0010, 7'h01, 1'b1, 2'd1, 1'b0);
    en = 1'b0;
    @(negedge clk);
    checkOff("en_drop0");
    @(negedge clk);
    checkOff("en_drop1");
    en = 1'b1;
    @(negedge clk);
    applyStimulus("restart", segNew, 4'b0100, 4, -1, segNew);

    // Asynchronous reset mid-ON must blank immediately
    #2 rst_n = 1'b0;
    #1 checkOff("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOff("rst_release");
    @(negedge clk);
    applyStimulus("post_rst", segNew, 4'b0100, 32, -1, segNew);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
